// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash read controller between two word fetchers, keeping one sequential stream open.
// Optional: define SPI_FLASH_ARB_RR_EN for round-robin arbitration with stream affinity.
module spi_flash_arbiter #(
  parameter int unsigned ADDR_BITS        = 24,
  parameter int unsigned DATA_WIDTH_BYTES = 2,
  parameter int unsigned IDLE_TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0,
  input  logic [ADDR_BITS-1:0]          addr0,
  input  logic                          req1,
  input  logic [ADDR_BITS-1:0]          addr1,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          valid0,
  output logic                          valid1,
  output logic [ADDR_BITS-1:0]          spi_addr,
  output logic                          spi_start_read,
  output logic                          spi_continue_read,
  output logic                          spi_stop_read,
  input  logic [8*DATA_WIDTH_BYTES-1:0] spi_data,
  input  logic                          spi_busy
);

  localparam int unsigned DATA_W   = 8 * DATA_WIDTH_BYTES;
  localparam int unsigned CNT_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned CNT_LAST = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
  localparam logic [ADDR_BITS-1:0] ADDR_STEP  = ADDR_BITS'(DATA_WIDTH_BYTES);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(DATA_WIDTH_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_OPEN,
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] next_addr_q, next_addr_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                 owner_q, owner_d;
  logic [DATA_W-1:0]    data_d;
  logic                 valid0_d, valid1_d;
  logic [ADDR_BITS-1:0] spi_addr_d;
  logic                 start_d, cont_d, stop_d;

  logic [ADDR_BITS-1:0] a0, a1, win_addr;
  logic                 req0_m, req1_m, any_req, win_sel;

  // Arbitration; a requester's held request is ignored during its own valid pulse.
  // owner_q doubles as the last-served record for round-robin.
  always_comb begin
    a0      = addr0 & ALIGN_MASK;
    a1      = addr1 & ALIGN_MASK;
    req0_m  = req0 & ~valid0;
    req1_m  = req1 & ~valid1;
    any_req = req0_m | req1_m;
`ifdef SPI_FLASH_ARB_RR_EN
    if (req0_m && req1_m) begin
      if ((state_q == ST_OPEN) && ((a0 == next_addr_q) != (a1 == next_addr_q)))
        win_sel = (a1 == next_addr_q);
      else
        win_sel = ~owner_q;
    end else begin
      win_sel = req1_m;
    end
`else
    win_sel = req1_m & ~req0_m;
`endif
    win_addr = win_sel ? a1 : a0;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    idle_cnt_d  = idle_cnt_q;
    owner_d     = owner_q;
    data_d      = data_out;
    valid0_d    = 1'b0;
    valid1_d    = 1'b0;
    spi_addr_d  = spi_addr;
    start_d     = 1'b0;
    cont_d      = 1'b0;
    stop_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          spi_addr_d  = win_addr;
          start_d     = 1'b1;
          next_addr_d = win_addr + ADDR_STEP;
          owner_d     = win_sel;
          idle_cnt_d  = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_XFER;
      ST_XFER: begin
        if (!spi_busy) begin
          data_d   = spi_data;
          valid0_d = ~owner_q;
          valid1_d = owner_q;
          state_d  = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (any_req) begin
          idle_cnt_d = '0;
          if (win_addr == next_addr_q) begin
            cont_d      = 1'b1;
            next_addr_d = next_addr_q + ADDR_STEP;
            owner_d     = win_sel;
            state_d     = ST_ISSUE;
          end else begin
            stop_d  = 1'b1;
            state_d = ST_STOP;
          end
        end else if (IDLE_TIMEOUT != 0) begin
          if (idle_cnt_q == CNT_W'(CNT_LAST)) begin
            stop_d     = 1'b1;
            idle_cnt_d = '0;
            state_d    = ST_STOP;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_STOP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      next_addr_q       <= '0;
      idle_cnt_q        <= '0;
      owner_q           <= 1'b0;
      data_out          <= '0;
      valid0            <= 1'b0;
      valid1            <= 1'b0;
      spi_addr          <= '0;
      spi_start_read    <= 1'b0;
      spi_continue_read <= 1'b0;
      spi_stop_read     <= 1'b0;
    end else begin
      state_q           <= state_d;
      next_addr_q       <= next_addr_d;
      idle_cnt_q        <= idle_cnt_d;
      owner_q           <= owner_d;
      data_out          <= data_d;
      valid0            <= valid0_d;
      valid1            <= valid1_d;
      spi_addr          <= spi_addr_d;
      spi_start_read    <= start_d;
      spi_continue_read <= cont_d;
      spi_stop_read     <= stop_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: behavioural flash controller, event monitor and in-order scoreboard.
`timescale 1ns/1ps
module tb_spi_flash_arbiter;

  localparam int AW      = 24;
  localparam int DW      = 16;
  localparam int BUSY_N  = 4;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic          who;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] data_out;
  logic          valid0, valid1;
  logic [AW-1:0] spi_addr;
  logic          spi_start_read, spi_continue_read, spi_stop_read;
  logic [DW-1:0] spi_data;
  logic          spi_busy;

  int checks = 0;
  int failures = 0;

  spi_flash_arbiter #(
    .ADDR_BITS(AW), .DATA_WIDTH_BYTES(2), .IDLE_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .data_out(data_out), .valid0(valid0), .valid1(valid1),
    .spi_addr(spi_addr), .spi_start_read(spi_start_read),
    .spi_continue_read(spi_continue_read), .spi_stop_read(spi_stop_read),
    .spi_data(spi_data), .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'hA5C3;
  endfunction

  function automatic exp_t mk_exp(input logic who, input logic [AW-1:0] a);
    exp_t e;
    e.who  = who;
    e.data = word_of(a & 24'hFFFFFE);
    return e;
  endfunction

  // Flash controller model: streams words from its own address counter
  logic [AW-1:0] ctl_addr;
  int            busy_cnt;
  always @(posedge clk) begin
    if (rst) begin
      spi_busy <= 1'b0; busy_cnt <= 0; ctl_addr <= '0; spi_data <= '0;
    end else if (spi_start_read) begin
      ctl_addr <= spi_addr; spi_busy <= 1'b1; busy_cnt <= BUSY_N;
    end else if (spi_continue_read) begin
      ctl_addr <= ctl_addr + 24'd2; spi_busy <= 1'b1; busy_cnt <= BUSY_N;
    end else if (spi_busy) begin
      if (busy_cnt == 1) begin
        spi_busy <= 1'b0;
        spi_data <= word_of(ctl_addr);
      end
      busy_cnt <= busy_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  int            n_start = 0, n_cont = 0, n_stop = 0, strobe_err = 0, vboth_err = 0, got_n = 0;
  int            last_start_cyc = 0, last_cont_cyc = 0, last_stop_cyc = 0;
  logic [AW-1:0] last_start_addr = '0;
  logic          got_who  [256];
  logic [DW-1:0] got_data [256];
  int            got_cyc  [256];
  always @(negedge clk) begin
    if (!rst) begin
      if (spi_start_read) begin
        n_start <= n_start + 1; last_start_cyc <= cyc; last_start_addr <= spi_addr;
      end
      if (spi_continue_read) begin
        n_cont <= n_cont + 1; last_cont_cyc <= cyc;
      end
      if (spi_stop_read) begin
        n_stop <= n_stop + 1; last_stop_cyc <= cyc;
      end
      if (32'(spi_start_read) + 32'(spi_continue_read) + 32'(spi_stop_read) > 1)
        strobe_err <= strobe_err + 1;
      if (valid0 && valid1) vboth_err <= vboth_err + 1;
      if ((valid0 || valid1) && got_n < 256) begin
        got_who[got_n]  <= valid1;
        got_data[got_n] <= data_out;
        got_cyc[got_n]  <= cyc;
        got_n           <= got_n + 1;
      end
    end
  end

  exp_t sb[$];
  int   rd = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Requester behaviour: wait for the target number of valids, dropping each req on its valid
  task automatic wait_got(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (valid0) req0 = 1'b0;
      if (valid1) req1 = 1'b0;
      if (got_n >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({data_out, valid0, valid1, spi_addr, spi_start_read, spi_continue_read, spi_stop_read} !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h v0=%b v1=%b addr=%h st=%b co=%b sp=%b expected all 0",
               data_out, valid0, valid1, spi_addr, spi_start_read, spi_continue_read, spi_stop_read);
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if ({valid0, valid1, spi_start_read, spi_continue_read, spi_stop_read, spi_addr} !== 29'd0) begin
      failures++;
      $display("FAIL reset_idle got v0=%b v1=%b st=%b co=%b sp=%b addr=%h expected quiet",
               valid0, valid1, spi_start_read, spi_continue_read, spi_stop_read, spi_addr);
    end
  endtask

  task automatic test_single();
    int s0, c0, p0, g0; bit ok; exp_t e;
    s0 = n_start; c0 = n_cont; p0 = n_stop; g0 = got_n;
    addr0 = 24'h000100; req0 = 1'b1;
    sb.push_back(mk_exp(1'b0, 24'h000100));
    wait_got(g0 + 1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout got no valid expected valid0"); end
    checks++;
    if (n_start - s0 != 1 || last_start_addr !== 24'h000100) begin
      failures++;
      $display("FAIL single_start got starts=%0d addr=%h expected 1 at 000100", n_start - s0, last_start_addr);
    end
    checks++;
    if (got_cyc[g0] - last_start_cyc != BUSY_N + 2) begin
      failures++;
      $display("FAIL single_latency got %0d expected %0d", got_cyc[g0] - last_start_cyc, BUSY_N + 2);
    end
    checks++;
    if (n_stop != p0 || n_cont != c0) begin
      failures++;
      $display("FAIL single_nostop got stops=%0d conts=%0d expected 0 0", n_stop - p0, n_cont - c0);
    end
    while (rd < got_n) begin
      e = '0; e.who = 1'bx;
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (got_who[rd] !== e.who || got_data[rd] !== e.data) begin
        failures++;
        $display("FAIL single_sb got who=%0d data=%h expected who=%0d data=%h", got_who[rd], got_data[rd], e.who, e.data);
      end
      rd++;
    end
  endtask

  task automatic test_sequential();
    int s0, c0, p0, g0; bit ok; exp_t e;
    logic [AW-1:0] seq [3];
    seq[0] = 24'h000100; seq[1] = 24'h000103; seq[2] = 24'h000104;
    tick(TIMEOUT + 5);
    s0 = n_start; c0 = n_cont; p0 = n_stop; g0 = got_n;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      addr0 = seq[i]; req0 = 1'b1;
      sb.push_back(mk_exp(1'b0, seq[i]));
      wait_got(g0 + i + 1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL seq_timeout word %0d got no valid", i); end
      if (i == 1) begin
        checks++;
        if (last_cont_cyc - got_cyc[g0] != 2) begin
          failures++;
          $display("FAIL seq_dead_cycle got valid-to-continue %0d expected 2", last_cont_cyc - got_cyc[g0]);
        end
      end
    end
    checks++;
    if (n_start - s0 != 1 || n_cont - c0 != 2 || n_stop != p0) begin
      failures++;
      $display("FAIL seq_strobes got st=%0d co=%0d sp=%0d expected 1 2 0", n_start - s0, n_cont - c0, n_stop - p0);
    end
    checks++;
    if (got_cyc[g0 + 2] - last_cont_cyc != BUSY_N + 2) begin
      failures++;
      $display("FAIL seq_cont_latency got %0d expected %0d", got_cyc[g0 + 2] - last_cont_cyc, BUSY_N + 2);
    end
    while (rd < got_n) begin
      e = '0; e.who = 1'bx;
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (got_who[rd] !== e.who || got_data[rd] !== e.data) begin
        failures++;
        $display("FAIL seq_sb got who=%0d data=%h expected who=%0d data=%h", got_who[rd], got_data[rd], e.who, e.data);
      end
      rd++;
    end
  endtask

  task automatic test_break();
    int s0, p0, g0; bit ok; exp_t e;
    tick(1);
    s0 = n_start; p0 = n_stop; g0 = got_n;
    addr1 = 24'h020000; req1 = 1'b1;
    sb.push_back(mk_exp(1'b1, 24'h020000));
    wait_got(g0 + 1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL break_timeout got no valid expected valid1"); end
    checks++;
    if (n_stop - p0 != 1 || n_start - s0 != 1 || last_start_addr !== 24'h020000) begin
      failures++;
      $display("FAIL break_strobes got sp=%0d st=%0d addr=%h expected 1 1 020000", n_stop - p0, n_start - s0, last_start_addr);
    end
    checks++;
    if (last_start_cyc - last_stop_cyc != 2) begin
      failures++;
      $display("FAIL break_restart_gap got %0d expected 2", last_start_cyc - last_stop_cyc);
    end
    while (rd < got_n) begin
      e = '0; e.who = 1'bx;
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (got_who[rd] !== e.who || got_data[rd] !== e.data) begin
        failures++;
        $display("FAIL break_sb got who=%0d data=%h expected who=%0d data=%h", got_who[rd], got_data[rd], e.who, e.data);
      end
      rd++;
    end
  endtask

  task automatic test_collision();
    int s0, p0, g0; bit ok; exp_t e;
    tick(TIMEOUT + 5);
    s0 = n_start; p0 = n_stop; g0 = got_n;
    addr0 = 24'h000200; addr1 = 24'h030000; req0 = 1'b1; req1 = 1'b1;
    sb.push_back(mk_exp(1'b0, 24'h000200));
    sb.push_back(mk_exp(1'b1, 24'h030000));
    wait_got(g0 + 2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL collide_timeout got %0d valids expected 2", got_n - g0); end
    checks++;
    if (n_start - s0 != 2 || n_stop - p0 != 1) begin
      failures++;
      $display("FAIL collide_strobes got st=%0d sp=%0d expected 2 1", n_start - s0, n_stop - p0);
    end
    while (rd < got_n) begin
      e = '0; e.who = 1'bx;
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (got_who[rd] !== e.who || got_data[rd] !== e.data) begin
        failures++;
        $display("FAIL collide_sb got who=%0d data=%h expected who=%0d data=%h", got_who[rd], got_data[rd], e.who, e.data);
      end
      rd++;
    end
  endtask

  task automatic test_timeout();
    int s0, c0, p0, vcyc;
    s0 = n_start; c0 = n_cont; p0 = n_stop; vcyc = got_cyc[got_n - 1];
    tick(TIMEOUT + 5);
    checks++;
    if (n_stop - p0 != 1 || last_stop_cyc - vcyc != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_stop got stops=%0d delay=%0d expected 1 after %0d", n_stop - p0, last_stop_cyc - vcyc, TIMEOUT);
    end
    tick(TIMEOUT + 5);
    checks++;
    if (n_stop - p0 != 1 || n_start != s0 || n_cont != c0) begin
      failures++;
      $display("FAIL timeout_quiet got sp=%0d st=%0d co=%0d expected 1 0 0", n_stop - p0, n_start - s0, n_cont - c0);
    end
  endtask

  task automatic test_wrap();
    int s0, c0, p0, g0; bit ok; exp_t e;
    logic [AW-1:0] seq [3];
    seq[0] = 24'hFFFFFC; seq[1] = 24'hFFFFFE; seq[2] = 24'h000000;
    s0 = n_start; c0 = n_cont; p0 = n_stop; g0 = got_n;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      addr0 = seq[i]; req0 = 1'b1;
      sb.push_back(mk_exp(1'b0, seq[i]));
      wait_got(g0 + i + 1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL wrap_timeout word %0d got no valid", i); end
    end
    checks++;
    if (n_start - s0 != 1 || n_cont - c0 != 2 || n_stop != p0 || last_start_addr !== 24'hFFFFFC) begin
      failures++;
      $display("FAIL wrap_strobes got st=%0d co=%0d sp=%0d addr=%h expected 1 2 0 fffffc",
               n_start - s0, n_cont - c0, n_stop - p0, last_start_addr);
    end
    while (rd < got_n) begin
      e = '0; e.who = 1'bx;
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (got_who[rd] !== e.who || got_data[rd] !== e.data) begin
        failures++;
        $display("FAIL wrap_sb got who=%0d data=%h expected who=%0d data=%h", got_who[rd], got_data[rd], e.who, e.data);
      end
      rd++;
    end
  endtask

  task automatic test_reset_mid();
    int s0, p0, g0; bit ok; exp_t e;
    tick(1);
    s0 = n_start; g0 = got_n;
    addr0 = 24'h000400; req0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (n_start != s0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_start got no start_read expected one"); end
    tick(2);
    rst = 1'b1; req0 = 1'b0;
    tick(1);
    checks++;
    if ({data_out, valid0, valid1, spi_addr, spi_start_read, spi_continue_read, spi_stop_read} !== 45'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got data=%h v0=%b v1=%b addr=%h st=%b co=%b sp=%b expected all 0",
               data_out, valid0, valid1, spi_addr, spi_start_read, spi_continue_read, spi_stop_read);
    end
    rst = 1'b0;
    tick(BUSY_N + 10);
    checks++;
    if (got_n != g0) begin failures++; $display("FAIL rstmid_novalid got %0d valids expected 0", got_n - g0); end
    s0 = n_start; p0 = n_stop;
    addr0 = 24'h000500; req0 = 1'b1;
    sb.push_back(mk_exp(1'b0, 24'h000500));
    wait_got(g0 + 1, ok);
    checks++;
    if (!ok || n_start - s0 != 1 || n_stop != p0) begin
      failures++;
      $display("FAIL rstmid_restart got ok=%0d st=%0d sp=%0d expected 1 1 0", ok, n_start - s0, n_stop - p0);
    end
    while (rd < got_n) begin
      e = '0; e.who = 1'bx;
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (got_who[rd] !== e.who || got_data[rd] !== e.data) begin
        failures++;
        $display("FAIL rstmid_sb got who=%0d data=%h expected who=%0d data=%h", got_who[rd], got_data[rd], e.who, e.data);
      end
      rd++;
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (strobe_err != 0) begin failures++; $display("FAIL multi_strobe got %0d cycles expected 0", strobe_err); end
    checks++;
    if (vboth_err != 0) begin failures++; $display("FAIL both_valid got %0d cycles expected 0", vboth_err); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d pending expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequential();
    test_break();
    test_collision();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
